// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register address width, scheduler FSM states
// and the default in-flight limit.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W           = 5;
  localparam int unsigned MAX_INFLIGHT_DEFAULT = 3;

  typedef enum logic {
    RUN,
    FLUSH
  } sched_state_t;

endpackage

// File: rtl/pending_counter.sv
// 2-bit saturating up/down counter; simultaneous inc and dec cancel out.
// clr is a synchronous clear that takes priority over inc/dec.
module pending_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] cnt
);

  logic [1:0] cnt_q, cnt_d;

  // Next count: clear, then saturating step in either direction.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 2'd0;
    end else if (inc && !dec && (cnt_q != 2'd3)) begin
      cnt_d = cnt_q + 2'd1;
    end else if (dec && !inc && (cnt_q != 2'd0)) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 2'd0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scheduler.sv
// Issue-stage hazard scheduler: per-register pending counters, in-flight limit,
// last-result forwarding select and a RUN/FLUSH drain state machine.
// Optional feature macro: HAZARD_FWD_EN enables forwarding from the last issued
// instruction; when undefined every pending used source stalls.
module hazard_scheduler
  import pipeline_pkg::*;
#(
  parameter int unsigned NREGS        = 32,
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic                  rs1_used_i,
  input  logic                  rs2_used_i,
  output logic                  issue_ready_o,
  output logic                  fwd_rs1_o,
  output logic                  fwd_rs2_o,
  input  logic                  retire_valid_i,
  input  logic [REG_ADDR_W-1:0] retire_rd_i,
  input  logic                  flush_i,
  output logic [1:0]            inflight_o,
  output logic                  busy_o
);

  localparam logic [1:0] MaxInflight = 2'(MAX_INFLIGHT);

  sched_state_t          state_q, state_d;
  logic [1:0]            inflight_q, inflight_d;
  logic [REG_ADDR_W-1:0] last_rd_q;
  logic                  last_valid_q;
  logic                  clr_all;
  logic                  issue_fire;
  logic                  retire_eff;
  logic                  haz1, haz2, sat;
  logic [1:0]            pend [NREGS];

  // A retire with nothing in flight is dropped entirely.
  assign retire_eff = retire_valid_i && (inflight_q != 2'd0);
  assign issue_fire = issue_valid_i && issue_ready_o;

  assign pend[0] = 2'd0;

  for (genvar r = 1; r < NREGS; r++) begin : g_pend
    pending_counter u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr_all),
      .inc (issue_fire && (rd_i == REG_ADDR_W'(r))),
      .dec (retire_eff && (retire_rd_i == REG_ADDR_W'(r))),
      .cnt (pend[r])
    );
  end

`ifdef HAZARD_FWD_EN
  // Forward only when the sole outstanding writer is the previous instruction.
  assign fwd_rs1_o = rs1_used_i && (rs1_i != '0) && last_valid_q &&
                     (rs1_i == last_rd_q) && (pend[rs1_i] == 2'd1);
  assign fwd_rs2_o = rs2_used_i && (rs2_i != '0) && last_valid_q &&
                     (rs2_i == last_rd_q) && (pend[rs2_i] == 2'd1);
`else
  assign fwd_rs1_o = 1'b0;
  assign fwd_rs2_o = 1'b0;
  logic unused_last;
  assign unused_last = ^{last_valid_q, last_rd_q};
`endif

  assign haz1 = rs1_used_i && (rs1_i != '0) && (pend[rs1_i] != 2'd0) && !fwd_rs1_o;
  assign haz2 = rs2_used_i && (rs2_i != '0) && (pend[rs2_i] != 2'd0) && !fwd_rs2_o;
  // Hold off an issue that would overflow its destination's pending counter.
  assign sat  = (rd_i != '0) && (pend[rd_i] == 2'd3);

  assign issue_ready_o = (state_q == RUN) && !haz1 && !haz2 && !sat &&
                         ((inflight_q < MaxInflight) || retire_valid_i);

  // FSM next state; leaving FLUSH clears all tracking.
  always_comb begin
    state_d = state_q;
    clr_all = 1'b0;
    unique case (state_q)
      RUN: begin
        if (flush_i) state_d = FLUSH;
      end
      FLUSH: begin
        if ((inflight_q == 2'd0) && !flush_i) begin
          state_d = RUN;
          clr_all = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // In-flight count: issue and retire in the same cycle cancel.
  always_comb begin
    inflight_d = inflight_q;
    if (issue_fire && !retire_eff)      inflight_d = inflight_q + 2'd1;
    else if (retire_eff && !issue_fire) inflight_d = inflight_q - 2'd1;
  end

  // State and in-flight registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      inflight_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
    end
  end

  // Track the most recent issue; a matching retire invalidates it unless a newer issue lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_valid_q <= 1'b0;
      last_rd_q    <= '0;
    end else if (clr_all) begin
      last_valid_q <= 1'b0;
    end else if (issue_fire) begin
      last_rd_q    <= rd_i;
      last_valid_q <= (rd_i != '0);
    end else if (retire_eff && (retire_rd_i == last_rd_q)) begin
      last_valid_q <= 1'b0;
    end
  end

  assign inflight_o = inflight_q;
  assign busy_o     = (state_q != RUN);

endmodule

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 SHALL have parameter NREGS, default 32, meaning number of architectural registers; x0 is hard-wired zero.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 3, meaning maximum issued-but-not-retired instructions (1..3).
REQ-003 SHALL have the port list: clk, input, 1 bit, single clock, all logic on its rising edge.
REQ-004 SHALL have the port list: rst, input, 1 bit, reset, synchronous and active-high.
REQ-005 SHALL have the port list: issue_valid_i, input, 1 bit, ID offers an instruction.
REQ-006 SHALL have the port list: rd_i / rs1_i / rs2_i, input, 5 bits each, destination and source register addresses.
REQ-007 SHALL have the port list: rs1_used_i / rs2_used_i, input, 1 bit each, source operand is read.
REQ-008 SHALL have the port list: issue_ready_o, input to ID is this output, 1 bit; instruction issues when issue_valid_i && issue_ready_o.
REQ-009 SHALL have the port list: fwd_rs1_o / fwd_rs2_o, output, 1 bit each, select last ALU result for the EX feedback mux; valid in the issue cycle.
REQ-010 SHALL have the port list: retire_valid_i, input, 1 bit, writeback of one in-flight instruction.
REQ-011 SHALL have the port list: retire_rd_i, input, 5 bits, register written back.
REQ-012 SHALL have the port list: flush_i, input, 1 bit, drain-and-clear request.
REQ-013 SHALL have the port list: inflight_o, output, 2 bits, current in-flight count.
REQ-014 SHALL have the port list: busy_o, output, 1 bit, state is not RUN.

Function
REQ-015 SHALL keep a 2-bit pending counter per register 1..NREGS-1; x0 is never pending and never forwarded or stalled on.
REQ-016 SHALL, on issue with rd_i != 0, increment pending[rd_i]; on retire with retire_rd_i != 0, decrement pending[retire_rd_i]; simultaneous issue and retire to the same register leaves it unchanged.
REQ-017 SHALL keep last_rd/last_valid for the most recently issued instruction; last_valid clears on a retire of that rd when no newer issue occurs in the same cycle.
REQ-018 SHALL assert fwd_rsN_o when rsN_used_i && rsN_i != 0 && last_valid && rsN_i == last_rd && pending[rsN_i] == 1.
REQ-019 SHALL treat a source as hazardous when it is used, nonzero, pending nonzero, and not forwardable per REQ-018.
REQ-020 SHALL drive issue_ready_o = (state==RUN) && no hazard && (inflight < MAX_INFLIGHT || retire_valid_i), combinationally with zero-cycle latency.
REQ-021 SHALL update inflight by +1 on issue and -1 on retire; simultaneous issue and retire leaves it unchanged; a retire at inflight==0 is ignored, with no underflow and no counter changes.
REQ-022 SHALL implement FSM RUN -> FLUSH on flush_i; FLUSH -> RUN when inflight==0 and flush_i is low; issue_ready_o is 0 in FLUSH; retires still count.
REQ-023 SHALL, on FLUSH exit, have all pending counters zero and last_valid=0.
REQ-024 SHALL give flush_i asserted in the same cycle as an issue handshake priority to the issue (counted), then enter FLUSH.
REQ-025 SHALL saturate a pending counter at 3; the issue that would overflow it is held off by issue_ready_o.

Reset
REQ-026 SHALL, on rst high at a clock edge, set state=RUN, inflight=0, all pending=0, last_valid=0, last_rd=0.
REQ-027 SHALL produce the following during and one cycle after reset: issue_ready_o=1, fwd_rs1_o=0, fwd_rs2_o=0, inflight_o=0, busy_o=0.
REQ-028 SHALL let reset mid-flush or mid-flight discard all tracking immediately; the environment is responsible for squashing in-flight work.

Configuration
REQ-029 SHALL, with HAZARD_FWD_EN defined, implement REQ-018 forwarding.
REQ-030 SHALL, with HAZARD_FWD_EN undefined, tie fwd_rs1_o/fwd_rs2_o to 0 and treat every pending used source as a hazard, with all other behaviour identical.

Structure
REQ-031 SHALL place REG_ADDR_W=5, the sched_state_t enum (RUN, FLUSH), and MAX_INFLIGHT default in shared package pipeline_pkg.
REQ-032 SHALL use one natural sub-module, pending_counter: a 2-bit saturating up/down counter with simultaneous inc/dec, instantiated NREGS-1 times.

Verification
REQ-033 SHALL cover: issue rd=5, next cycle issue rs1=5 used -> fwd_rs1_o=1, issue_ready_o=1.
REQ-034 SHALL cover: issue rd=5, then rd=6, then rs1=5 -> fwd_rs1_o=0, issue_ready_o=0 until retire rd=5, then ready=1; with HAZARD_FWD_EN undefined, the REQ-033 case also stalls.
REQ-035 SHALL cover: three issues with no retire -> inflight_o=3, issue_ready_o=0; retire_valid_i in the same cycle as the 4th offer -> issue accepted, inflight_o stays 3.
REQ-036 SHALL cover: rd=0 issue followed by a rs1=0 read -> no pending change, no forward, no stall.
REQ-037 SHALL cover: flush_i with inflight=2 -> busy_o=1 and ready=0 until the second retire; RUN on the next cycle with all pending=0.
REQ-038 SHALL cover: rst asserted with inflight=2 and state FLUSH -> next cycle inflight_o=0, busy_o=0, issue_ready_o=1.
